// File: rtl/fwd_scoreboard_unit.sv
// fwd_scoreboard_unit
//   Operand forwarder plus in-flight result scoreboard, placed between regfile
//   read and EX issue. Each source operand is taken from the youngest matching
//   forwarding bus (index 0 first) or from the regfile. A per-register
//   countdown tracks outstanding multi-cycle results; issue stalls on RAW and
//   WAW hazards against those countdowns.
//
//   Optional feature macro: FWD_STATS_EN adds saturating stall/forward counters.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   flush         clear all pending scoreboard entries at the next edge
//   iss_*         op being issued: valid, writes-rd, rd, latency, source addrs
//   rf_data       regfile read data, one DSIZE slot per source
//   fwd_*         forwarding buses: valid, destination address, data
//   opnd_data     resolved operands, one DSIZE slot per source
//   fwd_hit       per-source flag: operand came from a forwarding bus
//   stall         issue refused this cycle
//   stat_stall    (FWD_STATS_EN) count of stall cycles
//   stat_fwd      (FWD_STATS_EN) count of forwarded operands on accepted ops
module fwd_scoreboard_unit #(
  parameter int unsigned DSIZE  = 32,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned NFWD   = 2,
  parameter int unsigned MAXLAT = 4,
  parameter int unsigned LW     = $clog2(MAXLAT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   iss_valid,
  input  logic                   iss_we,
  input  logic [AWIDTH-1:0]      iss_rd,
  input  logic [LW-1:0]          iss_lat,
  input  logic [NSRC*AWIDTH-1:0] iss_rs,
  input  logic [NSRC*DSIZE-1:0]  rf_data,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD*AWIDTH-1:0] fwd_addr,
  input  logic [NFWD*DSIZE-1:0]  fwd_data,
  output logic [NSRC*DSIZE-1:0]  opnd_data,
  output logic [NSRC-1:0]        fwd_hit,
  output logic                   stall
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]            stat_stall,
  output logic [31:0]            stat_fwd
`endif
);

  localparam int unsigned NREG = 2 ** AWIDTH;

  logic [LW-1:0]   cnt_q [NREG];
  logic [LW-1:0]   cnt_d [NREG];
  logic [LW-1:0]   lat_eff;
  logic [NSRC-1:0] raw;
  logic            waw;
  logic            accept;

  // Requested latency clamped to 1..MAXLAT.
  always_comb begin
    if (iss_lat == '0) begin
      lat_eff = LW'(1);
    end else if (32'(iss_lat) > MAXLAT) begin
      lat_eff = LW'(MAXLAT);
    end else begin
      lat_eff = iss_lat;
    end
  end

  // Operand resolution and RAW detection per source.
  always_comb begin
    logic [AWIDTH-1:0] src;
    opnd_data = rf_data;
    fwd_hit   = '0;
    raw       = '0;
    for (int i = 0; i < NSRC; i++) begin
      src = iss_rs[i*AWIDTH +: AWIDTH];
      if (src != '0) begin
        // Walk from oldest to youngest so the lowest matching bus wins.
        for (int k = NFWD - 1; k >= 0; k--) begin
          if (fwd_valid[k] && (fwd_addr[k*AWIDTH +: AWIDTH] == src)) begin
            opnd_data[i*DSIZE +: DSIZE] = fwd_data[k*DSIZE +: DSIZE];
            fwd_hit[i]                  = 1'b1;
          end
        end
        raw[i] = (cnt_q[src] != '0);
      end
    end
  end

  // A new write must not retire before an older one to the same register.
  assign waw    = iss_we && (iss_rd != '0) && (cnt_q[iss_rd] > lat_eff);
  assign stall  = iss_valid && ((|raw) || waw);
  assign accept = iss_valid && !stall;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
      if (accept && iss_we && (r != 0) && (iss_rd == AWIDTH'(r))) begin
        cnt_d[r] = lat_eff;
      end
      if (flush || (r == 0)) begin
        cnt_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (rst) begin
        cnt_q[r] <= '0;
      end else begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] hit_cnt;
  logic [32:0] stall_sum;
  logic [32:0] fwd_sum;

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NSRC; i++) begin
      hit_cnt = hit_cnt + 32'(fwd_hit[i]);
    end
    stall_sum = {1'b0, stat_stall} + 33'(stall);
    fwd_sum   = {1'b0, stat_fwd} + (accept ? {1'b0, hit_cnt} : 33'd0);
  end

  // Saturating counters; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall <= '0;
      stat_fwd   <= '0;
    end else begin
      stat_stall <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
      stat_fwd   <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// tb_fwd_scoreboard_unit
//   Directed bench for fwd_scoreboard_unit. A reference model tracks, per
//   register, the absolute cycle at which its pending result becomes
//   available, and derives operands, hits and stall from that every cycle.
//   Hand-computed literal checks pin the main scenarios.
module tb_fwd_scoreboard_unit;

  localparam int DSIZE  = 32;
  localparam int AWIDTH = 5;
  localparam int NSRC   = 2;
  localparam int NFWD   = 2;
  localparam int MAXLAT = 4;
  localparam int LW     = 3;

  localparam logic [31:0] VA = 32'hAAAA_0001;
  localparam logic [31:0] VB = 32'hBBBB_0002;
  localparam logic [31:0] VX = 32'hCAFE_0005;
  localparam logic [31:0] VY = 32'hBEEF_0007;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   iss_valid;
  logic                   iss_we;
  logic [AWIDTH-1:0]      iss_rd;
  logic [LW-1:0]          iss_lat;
  logic [NSRC*AWIDTH-1:0] iss_rs;
  logic [NSRC*DSIZE-1:0]  rf_data;
  logic [NFWD-1:0]        fwd_valid;
  logic [NFWD*AWIDTH-1:0] fwd_addr;
  logic [NFWD*DSIZE-1:0]  fwd_data;
  logic [NSRC*DSIZE-1:0]  opnd_data;
  logic [NSRC-1:0]        fwd_hit;
  logic                   stall;
`ifdef FWD_STATS_EN
  logic [31:0]            stat_stall;
  logic [31:0]            stat_fwd;
`endif

  fwd_scoreboard_unit #(
    .DSIZE (DSIZE),
    .AWIDTH(AWIDTH),
    .NSRC  (NSRC),
    .NFWD  (NFWD),
    .MAXLAT(MAXLAT),
    .LW    (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .iss_valid(iss_valid),
    .iss_we   (iss_we),
    .iss_rd   (iss_rd),
    .iss_lat  (iss_lat),
    .iss_rs   (iss_rs),
    .rf_data  (rf_data),
    .fwd_valid(fwd_valid),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
    .opnd_data(opnd_data),
    .fwd_hit  (fwd_hit),
    .stall    (stall)
`ifdef FWD_STATS_EN
    ,
    .stat_stall(stat_stall),
    .stat_fwd  (stat_fwd)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit checking = 1'b0;

  // Model state: cycle number from which each register's result is available.
  int          ready_at [32] = '{default: 0};
  longint      m_stat_stall = 0;
  longint      m_stat_fwd   = 0;
  logic [63:0] e_opnd;
  logic [1:0]  e_hit;
  bit          e_stall;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_clamp(input logic [LW-1:0] l);
    if (l == 0) return 1;
    if (int'(l) > MAXLAT) return MAXLAT;
    return int'(l);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int a;
    int hits;
    int le;
    e_opnd  = rf_data;
    e_hit   = '0;
    e_stall = 1'b0;
    hits    = 0;
    le      = lat_clamp(iss_lat);
    for (int i = 0; i < NSRC; i++) begin
      a = int'(iss_rs[i*AWIDTH +: AWIDTH]);
      if (a != 0) begin
        for (int k = 0; k < NFWD; k++) begin
          if (!e_hit[i] && fwd_valid[k] && int'(fwd_addr[k*AWIDTH +: AWIDTH]) == a) begin
            e_opnd[i*DSIZE +: DSIZE] = fwd_data[k*DSIZE +: DSIZE];
            e_hit[i] = 1'b1;
            hits++;
          end
        end
        if (cyc < ready_at[a]) e_stall = iss_valid;
      end
    end
    if (iss_we && iss_rd != 0 && (ready_at[iss_rd] - cyc) > le) e_stall = iss_valid;

    if (checking) begin
      chk("cyc_opnd", opnd_data, e_opnd);
      chk("cyc_hit", 64'(fwd_hit), 64'(e_hit));
      chk("cyc_stall", 64'(stall), 64'(e_stall));
`ifdef FWD_STATS_EN
      chk("cyc_stat_stall", 64'(stat_stall), 64'(m_stat_stall));
      chk("cyc_stat_fwd", 64'(stat_fwd), 64'(m_stat_fwd));
`endif
    end

    // Advance the model to what the coming edge must produce.
    if (rst) begin
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      m_stat_stall = 0;
      m_stat_fwd   = 0;
    end else begin
      if (e_stall) m_stat_stall = (m_stat_stall >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stat_stall + 1;
      if (iss_valid && !e_stall) begin
        m_stat_fwd = m_stat_fwd + hits;
        if (m_stat_fwd > 64'hFFFF_FFFF) m_stat_fwd = 64'hFFFF_FFFF;
      end
      if (flush) begin
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
      end else if (iss_valid && !e_stall && iss_we && iss_rd != 0) begin
        ready_at[iss_rd] = cyc + le + 1;
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_we = 1'b0; iss_rd = '0; iss_lat = '0;
    iss_rs = '0; rf_data = '0; fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
    step();
    checking = 1'b1;
    step();
    rst = 1'b0;

    // Plain regfile read after reset.
    iss_valid = 1'b1; iss_rs = {5'd4, 5'd3}; rf_data = {VB, VA};
    #2;
    chk("t1_opnd", opnd_data, {VB, VA});
    chk("t1_hit", 64'(fwd_hit), 64'd0);
    chk("t1_stall", 64'(stall), 64'd0);
    step();

    // rd=5 lat=3: consumer stalls three cycles, then forwards from bus 0.
    iss_we = 1'b1; iss_rd = 5'd5; iss_lat = 3'd3; iss_rs = '0;
    step();
    iss_we = 1'b0; iss_rs = {5'd0, 5'd5};
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t2_raw_stall", 64'(stall), 64'd1);
      step();
    end
    fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd5}; fwd_data = {VY, VX}; iss_rs = {5'd5, 5'd5};
    #2;
    chk("t2_fwd_opnd", opnd_data, {VX, VX});
    chk("t2_fwd_hit", 64'(fwd_hit), 64'd3);
    chk("t2_fwd_stall", 64'(stall), 64'd0);
    step();
    fwd_valid = '0; iss_valid = 1'b0;
`ifdef FWD_STATS_EN
    #2;
    chk("t6_stat_stall", 64'(stat_stall), 64'd3);
    chk("t6_stat_fwd", 64'(stat_fwd), 64'd2);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef FWD_STATS_EN
    #2;
    chk("t6_flush_stall", 64'(stat_stall), 64'd3);
    chk("t6_flush_fwd", 64'(stat_fwd), 64'd2);
`endif

    // Bus priority and the zero register.
    iss_valid = 1'b1; fwd_valid = 2'b11; fwd_addr = {5'd7, 5'd7}; fwd_data = {VY, VX};
    iss_rs = {5'd0, 5'd7}; rf_data = {VB, VA};
    #2;
    chk("t3_prio_opnd", opnd_data, {VB, VX});
    chk("t3_prio_hit", 64'(fwd_hit), 64'd1);
    step();
    fwd_valid = 2'b01; fwd_addr = {5'd7, 5'd0}; iss_rs = '0;
    #2;
    chk("t3_zero_opnd", opnd_data, {VB, VA});
    chk("t3_zero_hit", 64'(fwd_hit), 64'd0);
    step();
    fwd_valid = '0;

    // WAW: rd=6 lat=4 in flight.
    iss_we = 1'b1; iss_rd = 5'd6; iss_lat = 3'd4;
    step();
    iss_lat = 3'd1;
    #2;
    chk("t4_waw_stall", 64'(stall), 64'd1);
    step();
    iss_valid = 1'b0;
    step();
    iss_valid = 1'b1; iss_lat = 3'd4;
    #2;
    chk("t4_waw_accept", 64'(stall), 64'd0);
    step();
    iss_lat = 3'd3;
    #2;
    chk("t4_cnt4_stall", 64'(stall), 64'd1);
    step();
    iss_lat = 3'd7;
    #2;
    chk("t4_clamp_hi", 64'(stall), 64'd0);
    step();
    iss_lat = 3'd0;
    #2;
    chk("t4_clamp_lo", 64'(stall), 64'd1);
    step();
    iss_valid = 1'b0; iss_we = 1'b0;
    repeat (5) step();

    // Flush discards a pending result but not the current-cycle stall.
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd8; iss_lat = 3'd4; iss_rs = '0;
    step();
    iss_we = 1'b0; iss_rs = {5'd0, 5'd8}; flush = 1'b1;
    #2;
    chk("t5_flush_same", 64'(stall), 64'd1);
    step();
    flush = 1'b0;
    #2;
    chk("t5_after_flush", 64'(stall), 64'd0);
    step();

    // Same with reset.
    iss_we = 1'b1; iss_rs = '0;
    step();
    iss_we = 1'b0; iss_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; iss_valid = 1'b1; iss_rs = {5'd0, 5'd8};
    #2;
    chk("t5_after_rst", 64'(stall), 64'd0);
`ifdef FWD_STATS_EN
    chk("t6_rst_stall", 64'(stat_stall), 64'd0);
    chk("t6_rst_fwd", 64'(stat_fwd), 64'd0);
`endif
    step();
    iss_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
